// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: log2 sizing and pointer-width derivation.
package fifo_pkg;

   // Ceiling log2 as a constant function, usable in parameter and port widths.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   // Pointer width: index bits plus one wrap bit, so full and empty are distinguishable.
   function automatic int ptr_width(input int depth);
      return clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// FIFO storage array: one synchronous write port, one combinational read port.
module fifo_mem_2p
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8,
   parameter int ADDR_WIDTH = clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Storage is intentionally not reset; only the pointers decide what is valid.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_sync_flags.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags,
// one-cycle overflow/underflow pulses and selectable FWFT read mode.
module fifo_sync_flags
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 8,
   parameter int AF_THRESH  = FIFO_DEPTH - 2,
   parameter int AE_THRESH  = 2,
   parameter int FWFT       = 0
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             cs,
   input  logic                             wr_en,
   input  logic                             rd_en,
   input  logic [DATA_WIDTH-1:0]            data_in,
   output logic [DATA_WIDTH-1:0]            data_out,
   output logic                             empty,
   output logic                             full,
   output logic                             almost_empty,
   output logic                             almost_full,
   output logic [ptr_width(FIFO_DEPTH)-1:0] count,
   output logic                             overflow,
   output logic                             underflow
);

   localparam int AW = clog2(FIFO_DEPTH);
   localparam int PW = ptr_width(FIFO_DEPTH);

   localparam logic [PW-1:0] DEPTH_C = PW'(FIFO_DEPTH);
   localparam logic [PW-1:0] AF_C    = PW'(AF_THRESH);
   localparam logic [PW-1:0] AE_C    = PW'(AE_THRESH);
   localparam logic [PW-1:0] ONE_C   = PW'(1);

   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [PW-1:0]         wr_ptr_nxt;
   logic [PW-1:0]         rd_ptr_nxt;
   logic [PW-1:0]         count_nxt;
   logic                  wr_acc;
   logic                  rd_acc;
   logic [DATA_WIDTH-1:0] mem_rd_data;

   // Accept logic and next-state pointers; a write into a full FIFO only
   // goes through when a read frees a slot on the same edge.
   always_comb begin
      rd_acc     = cs & rd_en & ~empty;
      wr_acc     = cs & wr_en & (~full | rd_acc);
      wr_ptr_nxt = wr_ptr;
      rd_ptr_nxt = rd_ptr;
      if (wr_acc) wr_ptr_nxt = wr_ptr + ONE_C;
      if (rd_acc) rd_ptr_nxt = rd_ptr + ONE_C;
      count_nxt  = wr_ptr_nxt - rd_ptr_nxt;
   end

   // Pointers, count and flags are all registered from the next-state pointers,
   // so they describe the FIFO as it stands right after the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         empty        <= 1'b1;
         full         <= 1'b0;
         almost_empty <= 1'b1;
         almost_full  <= 1'b0;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         wr_ptr       <= wr_ptr_nxt;
         rd_ptr       <= rd_ptr_nxt;
         count        <= count_nxt;
         empty        <= (count_nxt == '0);
         full         <= (count_nxt == DEPTH_C);
         almost_empty <= (count_nxt <= AE_C);
         almost_full  <= (count_nxt >= AF_C);
         overflow     <= cs & wr_en & full & ~rd_acc;
         underflow    <= cs & rd_en & empty;
      end
   end

   fifo_mem_2p #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH),
      .ADDR_WIDTH (AW)
   ) u_mem (
      .clk     (clk),
      .wr_en   (wr_acc),
      .wr_addr (wr_ptr[AW-1:0]),
      .wr_data (data_in),
      .rd_addr (rd_ptr[AW-1:0]),
      .rd_data (mem_rd_data)
   );

   generate
      if (FWFT != 0) begin : g_fwft
         // Head word is presented directly; forced to zero while empty so
         // unwritten storage never leaks out after reset.
         assign data_out = empty ? '0 : mem_rd_data;
      end else begin : g_std
         // Registered read: the popped head word appears the cycle after rd_acc.
         always_ff @(posedge clk) begin
            if (rst)         data_out <= '0;
            else if (rd_acc) data_out <= mem_rd_data;
         end
      end
   endgenerate

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Directed self-checking bench: a standard-read instance and an FWFT instance.
module tb_fifo_sync_flags;

   logic        clk = 1'b0;
   logic        rst;
   logic        cs0, wr0, rd0, cs1, wr1, rd1;
   logic [31:0] din0, din1, dout0, dout1;
   logic        empty0, full0, ae0, af0, ovf0, unf0;
   logic        empty1, full1, ae1, af1, ovf1, unf1;
   logic [3:0]  cnt0, cnt1;
   int          total = 0;
   int          bad = 0;

   fifo_sync_flags #(.DATA_WIDTH(32), .FIFO_DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(0)) dut0 (
      .clk(clk), .rst(rst), .cs(cs0), .wr_en(wr0), .rd_en(rd0), .data_in(din0), .data_out(dout0),
      .empty(empty0), .full(full0), .almost_empty(ae0), .almost_full(af0), .count(cnt0),
      .overflow(ovf0), .underflow(unf0));

   fifo_sync_flags #(.DATA_WIDTH(32), .FIFO_DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1)) dut1 (
      .clk(clk), .rst(rst), .cs(cs1), .wr_en(wr1), .rd_en(rd1), .data_in(din1), .data_out(dout1),
      .empty(empty1), .full(full1), .almost_empty(ae1), .almost_full(af1), .count(cnt1),
      .overflow(ovf1), .underflow(unf1));

   always #5 clk = ~clk;

   // Advance one clock edge and settle before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle0();
      cs0 = 1'b1; wr0 = 1'b0; rd0 = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; tick(); rst = 1'b0;
      total++; if (cnt0 !== 4'd0)   begin bad++; $display("[TB] FAIL reset_count: got %0d want 0", cnt0); end
      total++; if (empty0 !== 1'b1) begin bad++; $display("[TB] FAIL reset_empty: got %b want 1", empty0); end
      total++; if (full0 !== 1'b0)  begin bad++; $display("[TB] FAIL reset_full: got %b want 0", full0); end
      total++; if (ae0 !== 1'b1)    begin bad++; $display("[TB] FAIL reset_ae: got %b want 1", ae0); end
      total++; if (af0 !== 1'b0)    begin bad++; $display("[TB] FAIL reset_af: got %b want 0", af0); end
      total++; if ({ovf0, unf0} !== 2'b00) begin bad++; $display("[TB] FAIL reset_err: got %b want 00", {ovf0, unf0}); end
      total++; if (dout0 !== 32'h0) begin bad++; $display("[TB] FAIL reset_dout: got %h want 0", dout0); end
   endtask

   task automatic test_fill_overflow();
      for (int i = 1; i <= 8; i++) begin
         idle0(); wr0 = 1'b1; din0 = 32'(i); tick();
         total++; if (cnt0 !== 4'(i)) begin bad++; $display("[TB] FAIL fill_count%0d: got %0d want %0d", i, cnt0, i); end
         total++; if (empty0 !== 1'b0) begin bad++; $display("[TB] FAIL fill_empty%0d: got %b want 0", i, empty0); end
         total++; if (full0 !== (i == 8)) begin bad++; $display("[TB] FAIL fill_full%0d: got %b want %b", i, full0, (i == 8)); end
         total++; if (af0 !== (i >= 6)) begin bad++; $display("[TB] FAIL fill_af%0d: got %b want %b", i, af0, (i >= 6)); end
         total++; if (ae0 !== (i <= 2)) begin bad++; $display("[TB] FAIL fill_ae%0d: got %b want %b", i, ae0, (i <= 2)); end
         total++; if (ovf0 !== 1'b0) begin bad++; $display("[TB] FAIL fill_ovf%0d: got %b want 0", i, ovf0); end
      end
      din0 = 32'hDEADBEEF; tick();
      total++; if (ovf0 !== 1'b1) begin bad++; $display("[TB] FAIL ovf_pulse: got %b want 1", ovf0); end
      total++; if (cnt0 !== 4'd8) begin bad++; $display("[TB] FAIL ovf_count: got %0d want 8", cnt0); end
      idle0(); tick();
      total++; if (ovf0 !== 1'b0) begin bad++; $display("[TB] FAIL ovf_clear: got %b want 0", ovf0); end
   endtask

   task automatic test_chip_select();
      cs0 = 1'b0; wr0 = 1'b1; rd0 = 1'b1; din0 = 32'h12345678; tick();
      total++; if (cnt0 !== 4'd8) begin bad++; $display("[TB] FAIL cs_count: got %0d want 8", cnt0); end
      total++; if ({ovf0, unf0} !== 2'b00) begin bad++; $display("[TB] FAIL cs_err: got %b want 00", {ovf0, unf0}); end
      total++; if (dout0 !== 32'h0) begin bad++; $display("[TB] FAIL cs_dout: got %h want 0", dout0); end
      idle0();
   endtask

   task automatic test_read_std();
      logic [31:0] exp_tail [6];
      exp_tail = '{32'h5, 32'h6, 32'h7, 32'h8, 32'hAABBCCDD, 32'h11223344};
      for (int i = 1; i <= 4; i++) begin
         idle0(); rd0 = 1'b1; tick();
         total++; if (dout0 !== 32'(i)) begin bad++; $display("[TB] FAIL rd_data%0d: got %h want %h", i, dout0, i); end
         total++; if (cnt0 !== 4'(8 - i)) begin bad++; $display("[TB] FAIL rd_count%0d: got %0d want %0d", i, cnt0, 8 - i); end
      end
      idle0(); wr0 = 1'b1; din0 = 32'hAABBCCDD; tick();
      din0 = 32'h11223344; tick();
      total++; if (cnt0 !== 4'd6) begin bad++; $display("[TB] FAIL wrap_count: got %0d want 6", cnt0); end
      for (int i = 0; i < 6; i++) begin
         idle0(); rd0 = 1'b1; tick();
         total++; if (dout0 !== exp_tail[i]) begin bad++; $display("[TB] FAIL wrap_data%0d: got %h want %h", i, dout0, exp_tail[i]); end
         total++; if (cnt0 !== 4'(5 - i)) begin bad++; $display("[TB] FAIL wrap_cnt%0d: got %0d want %0d", i, cnt0, 5 - i); end
      end
      total++; if (empty0 !== 1'b1) begin bad++; $display("[TB] FAIL drain_empty: got %b want 1", empty0); end
      tick();
      total++; if (unf0 !== 1'b1) begin bad++; $display("[TB] FAIL unf_pulse: got %b want 1", unf0); end
      total++; if (dout0 !== 32'h11223344) begin bad++; $display("[TB] FAIL unf_hold: got %h want 11223344", dout0); end
      idle0(); tick();
      total++; if (unf0 !== 1'b0) begin bad++; $display("[TB] FAIL unf_clear: got %b want 0", unf0); end
   endtask

   task automatic test_full_simultaneous();
      for (int i = 0; i < 8; i++) begin
         idle0(); wr0 = 1'b1; din0 = 32'h10 + 32'(i); tick();
      end
      total++; if (full0 !== 1'b1) begin bad++; $display("[TB] FAIL fs_prefull: got %b want 1", full0); end
      idle0(); wr0 = 1'b1; rd0 = 1'b1; din0 = 32'h55; tick();
      total++; if (dout0 !== 32'h10) begin bad++; $display("[TB] FAIL fs_head: got %h want 10", dout0); end
      total++; if (cnt0 !== 4'd8) begin bad++; $display("[TB] FAIL fs_count: got %0d want 8", cnt0); end
      total++; if (full0 !== 1'b1) begin bad++; $display("[TB] FAIL fs_full: got %b want 1", full0); end
      total++; if (ovf0 !== 1'b0) begin bad++; $display("[TB] FAIL fs_ovf: got %b want 0", ovf0); end
      for (int i = 1; i <= 8; i++) begin
         idle0(); rd0 = 1'b1; tick();
         total++; if (dout0 !== ((i == 8) ? 32'h55 : 32'h10 + 32'(i)))
            begin bad++; $display("[TB] FAIL fs_drain%0d: got %h want %h", i, dout0, (i == 8) ? 32'h55 : 32'h10 + 32'(i)); end
      end
      total++; if (cnt0 !== 4'd0) begin bad++; $display("[TB] FAIL fs_final: got %0d want 0", cnt0); end
      idle0(); tick();
   endtask

   task automatic test_empty_simultaneous();
      idle0(); wr0 = 1'b1; rd0 = 1'b1; din0 = 32'h77; tick();
      total++; if (unf0 !== 1'b1) begin bad++; $display("[TB] FAIL es_unf: got %b want 1", unf0); end
      total++; if (cnt0 !== 4'd1) begin bad++; $display("[TB] FAIL es_count: got %0d want 1", cnt0); end
      total++; if (empty0 !== 1'b0) begin bad++; $display("[TB] FAIL es_empty: got %b want 0", empty0); end
      idle0(); rd0 = 1'b1; tick();
      total++; if (dout0 !== 32'h77) begin bad++; $display("[TB] FAIL es_data: got %h want 77", dout0); end
      total++; if (cnt0 !== 4'd0) begin bad++; $display("[TB] FAIL es_drain: got %0d want 0", cnt0); end
      total++; if (unf0 !== 1'b0) begin bad++; $display("[TB] FAIL es_unf_clear: got %b want 0", unf0); end
      idle0(); tick();
   endtask

   task automatic test_fwft();
      total++; if (dout1 !== 32'h0 || empty1 !== 1'b1) begin bad++; $display("[TB] FAIL fw_reset: got %h/%b want 0/1", dout1, empty1); end
      cs1 = 1'b1; wr1 = 1'b1; din1 = 32'hA5; tick();
      total++; if (dout1 !== 32'hA5) begin bad++; $display("[TB] FAIL fw_show: got %h want a5", dout1); end
      total++; if (empty1 !== 1'b0) begin bad++; $display("[TB] FAIL fw_empty: got %b want 0", empty1); end
      din1 = 32'hB6; tick();
      wr1 = 1'b0; tick();
      total++; if (dout1 !== 32'hA5 || cnt1 !== 4'd2) begin bad++; $display("[TB] FAIL fw_hold: got %h/%0d want a5/2", dout1, cnt1); end
      rd1 = 1'b1; tick();
      total++; if (dout1 !== 32'hB6 || cnt1 !== 4'd1) begin bad++; $display("[TB] FAIL fw_pop: got %h/%0d want b6/1", dout1, cnt1); end
      tick();
      total++; if (empty1 !== 1'b1 || cnt1 !== 4'd0) begin bad++; $display("[TB] FAIL fw_drain: got %b/%0d want 1/0", empty1, cnt1); end
      rd1 = 1'b0; tick();
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) begin
         idle0(); wr0 = 1'b1; din0 = 32'h100 + 32'(i); tick();
      end
      idle0(); rd0 = 1'b1; tick();
      total++; if (dout0 !== 32'h100 || cnt0 !== 4'd4) begin bad++; $display("[TB] FAIL mid_pre: got %h/%0d want 100/4", dout0, cnt0); end
      rst = 1'b1; wr0 = 1'b1; rd0 = 1'b1; din0 = 32'hBAD; tick(); rst = 1'b0;
      total++; if (cnt0 !== 4'd0 || empty0 !== 1'b1 || ae0 !== 1'b1) begin bad++; $display("[TB] FAIL mid_flags: got %0d/%b/%b want 0/1/1", cnt0, empty0, ae0); end
      total++; if (dout0 !== 32'h0 || full0 !== 1'b0 || af0 !== 1'b0) begin bad++; $display("[TB] FAIL mid_dout: got %h/%b/%b want 0/0/0", dout0, full0, af0); end
      total++; if ({ovf0, unf0} !== 2'b00) begin bad++; $display("[TB] FAIL mid_err: got %b want 00", {ovf0, unf0}); end
      idle0(); wr0 = 1'b1; din0 = 32'h99; tick();
      idle0(); rd0 = 1'b1; tick();
      total++; if (dout0 !== 32'h99) begin bad++; $display("[TB] FAIL mid_fresh: got %h want 99", dout0); end
      total++; if (empty0 !== 1'b1) begin bad++; $display("[TB] FAIL mid_empty: got %b want 1", empty0); end
      idle0(); tick();
   endtask

   initial begin
      rst = 1'b1;
      cs0 = 1'b0; wr0 = 1'b0; rd0 = 1'b0; din0 = '0;
      cs1 = 1'b0; wr1 = 1'b0; rd1 = 1'b0; din1 = '0;
      $display("[TB] start");
      test_reset();
      test_fill_overflow();
      test_chip_select();
      test_read_std();
      test_full_simultaneous();
      test_empty_simultaneous();
      test_fwft();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout want finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/fifo_sync_flags.md
# fifo_sync_flags

Parametrised synchronous FIFO, next generation of the team's single-clock 32×8 FIFO: configurable width and depth, occupancy count, programmable almost-full/almost-empty thresholds, sticky-free overflow/underflow error pulses, and a selectable first-word-fall-through (FWFT) read mode. It sits between a producer and a consumer in the same clock domain, gated by a chip-select as before.

## Interface
- DATA_WIDTH, 32, data word width (≥1)
- FIFO_DEPTH, 8, number of entries; power of two, ≥2
- AF_THRESH, FIFO_DEPTH-2, almost_full asserted when count ≥ AF_THRESH (1..FIFO_DEPTH)
- AE_THRESH, 2, almost_empty asserted when count ≤ AE_THRESH (0..FIFO_DEPTH-1)
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through
- clk  in  1  clock; one clock, all logic on rising edge
- rst  in  1  reset; synchronous and active-high
- cs  in  1  chip select; wr_en/rd_en ignored when low
- wr_en  in  1  write request
- rd_en  in  1  read request
- data_in  in  DATA_WIDTH  write data
- data_out  out  DATA_WIDTH  read data
- empty  out  1  no entries
- full  out  1  FIFO_DEPTH entries
- almost_empty  out  1  count ≤ AE_THRESH
- almost_full  out  1  count ≥ AF_THRESH
- count  out  $clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH
- overflow  out  1  one-cycle pulse: write requested while full and not accepted
- underflow  out  1  one-cycle pulse: read requested while empty

## Operation
- wr_acc = cs & wr_en & (!full | rd_acc); rd_acc = cs & rd_en & !empty.
- Write while full is accepted only if a read is accepted in the same cycle (count unchanged).
- Read while empty always rejected, even with simultaneous write (write accepted, count 0→1).
- Pointers: $clog2(FIFO_DEPTH)+1 bits, MSB is wrap bit; count = wr_ptr − rd_ptr (modulo 2^width); full when count == FIFO_DEPTH, empty when count == 0. Wrap of the index bits at FIFO_DEPTH−1 → 0 is natural rollover.
- All flags and count are registered, derived from next-state pointers, so they are valid the cycle after the accepting edge.
- overflow = cs & wr_en & full & !rd_acc, registered; underflow = cs & rd_en & empty, registered. Rejected operations leave pointers, memory and data_out untouched.
- Memory contents are not reset; only pointers, flags and data_out.

## Timing
- Reset (rst high at clk edge): pointers 0, count 0, empty 1, full 0, almost_empty 1, almost_full 0, overflow 0, underflow 0, data_out 0. Reset mid-operation discards all contents; same-cycle wr_en/rd_en ignored.
- FWFT=0: data_out registered; updates the cycle after rd_acc with the head word, holds otherwise. Read latency 1 cycle.
- FWFT=1: data_out = mem[rd_ptr index] whenever !empty (0 after reset until first write); rd_acc pops and advances to the next word the following cycle. A write into an empty FIFO is visible on data_out, with empty low, one cycle after the write edge.
- Write latency: word readable (rd_acc possible) the cycle after wr_acc.
- Simultaneous wr_acc and rd_acc at any non-empty occupancy: count unchanged, both pointers advance.

## Structure
- Shared package fifo_pkg: clog2 helper function and pointer-width constant derivation; reused by later FIFO variants.
- One sub-module fifo_mem_2p: FIFO_DEPTH×DATA_WIDTH register array, one write port (wr_en, wr_addr, wr_data), one combinational read port; top holds pointers, flags, count, error pulses and the FWFT/standard output mux via generate on FWFT.

## Test plan
- Reset, then 8 writes of 0x1..0x8 (defaults) -> count 1..8, almost_full at count 6, full after 8th write, empty drops after 1st; 9th write 0xDEADBEEF -> overflow pulse one cycle, count stays 8.
- FWFT=0: 4 reads -> data_out 0x1,0x2,0x3,0x4 each one cycle after rd_acc; count 4; then write 0xAABBCCDD, 0x11223344 and read 6 -> 0x5..0x8, 0xAABBCCDD, 0x11223344 (pointer wrap covered); extra read -> underflow pulse, data_out holds 0x11223344.
- Full FIFO with simultaneous cs/wr_en/rd_en, data_in 0x55 -> read returns head, write accepted, count stays 8, full stays 1, no overflow.
- Empty FIFO with simultaneous write 0x77 and read -> underflow pulse, count 1, next read returns 0x77.
- FWFT=1: write 0xA5 to empty -> data_out 0xA5 and empty 0 next cycle without a read; rd_acc -> empty 1 next cycle.
- Fill to 5 then assert rst for one cycle -> all outputs at reset values next cycle; subsequent write/read returns new data, not stale entries.
